// File: rtl/idu_inst_buffer_pkg.sv
// idu_inst_buffer_pkg: shared widths and packet type for the decode-side instruction buffer
package idu_inst_buffer_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } pkt_t;
endpackage

// File: rtl/idu_inst_buffer.sv
// idu_inst_buffer: small FIFO of fetch packets between IFU and decoder, flushable on redirect
module idu_inst_buffer
  import idu_inst_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid,
  output logic                       if_ready,
  input  logic [XLEN-1:0]            if_pc,
  input  logic [ILEN-1:0]            if_inst,
  input  logic                       flush,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [XLEN-1:0]            id_pc,
  output logic [ILEN-1:0]            id_inst,
  output logic                       id_misalign,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  pkt_t          mem_q [DEPTH];
  pkt_t          head;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;
  // readiness ignores id_ready so a full buffer never accepts on a pop cycle
  assign if_ready    = (cnt_q != CW'(DEPTH)) && !flush && !rst;
  assign id_valid    = (cnt_q != '0) && !flush && !rst;
  assign push        = if_valid && if_ready;
  assign pop         = id_valid && id_ready;
  assign head        = mem_q[rd_q];
  assign id_pc       = id_valid ? head.pc : '0;
  assign id_inst     = id_valid ? head.inst : '0;
  assign id_misalign = id_valid && |head.pc[1:0];
  assign count       = cnt_q;
  always_comb begin
    rd_d  = flush ? '0 : rd_q + AW'(pop);
    wr_d  = flush ? '0 : wr_q + AW'(push);
    cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {if_pc, if_inst};
  end
endmodule

// File: tb/tb_idu_inst_buffer.sv
// tb_idu_inst_buffer: directed checks on a DEPTH=2 buffer, randomized queue-model checks on DEPTH=4
module tb_idu_inst_buffer;
  import idu_inst_buffer_pkg::*;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic            a_if_valid = 0, a_flush = 0, a_id_ready = 0;
  logic [XLEN-1:0] a_if_pc = 0;
  logic [ILEN-1:0] a_if_inst = 0;
  logic            a_if_ready, a_id_valid, a_id_misalign;
  logic [XLEN-1:0] a_id_pc;
  logic [ILEN-1:0] a_id_inst;
  logic [1:0]      a_count;
  logic            b_if_valid = 0, b_flush = 0, b_id_ready = 0;
  logic [XLEN-1:0] b_if_pc = 0;
  logic [ILEN-1:0] b_if_inst = 0;
  logic            b_if_ready, b_id_valid, b_id_misalign;
  logic [XLEN-1:0] b_id_pc;
  logic [ILEN-1:0] b_id_inst;
  logic [2:0]      b_count;
  logic [63:0]     q[$];
  idu_inst_buffer #(.DEPTH(2)) dut_a (
    .clk(clk), .rst(rst), .if_valid(a_if_valid), .if_ready(a_if_ready), .if_pc(a_if_pc),
    .if_inst(a_if_inst), .flush(a_flush), .id_valid(a_id_valid), .id_ready(a_id_ready),
    .id_pc(a_id_pc), .id_inst(a_id_inst), .id_misalign(a_id_misalign), .count(a_count)
  );
  idu_inst_buffer #(.DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .if_valid(b_if_valid), .if_ready(b_if_ready), .if_pc(b_if_pc),
    .if_inst(b_if_inst), .flush(b_flush), .id_valid(b_id_valid), .id_ready(b_id_ready),
    .id_pc(b_id_pc), .id_inst(b_id_inst), .id_misalign(b_id_misalign), .count(b_count)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic push_a(input logic [31:0] pc, input logic [31:0] inst);
    a_if_valid = 1;
    a_if_pc    = pc;
    a_if_inst  = inst;
  endtask
  initial begin
    logic [63:0] head;
    int          n;
    logic        exp_ir, exp_iv;
    // reset state
    cyc(); cyc();
    @(negedge clk);
    chk("rst_if_ready", a_if_ready, 0);
    chk("rst_id_valid", a_id_valid, 0);
    chk("rst_count", a_count, 0);
    chk("rst_id_pc", a_id_pc, 0);
    chk("rst_b_count", b_count, 0);
    cyc(); rst = 0;
    @(negedge clk);
    chk("post_rst_if_ready", a_if_ready, 1);
    // single push, latency 1
    cyc(); push_a(32'h100, 32'h13); a_id_ready = 1;
    @(negedge clk);
    chk("no_passthru", a_id_valid, 0);
    cyc(); a_if_valid = 0;
    @(negedge clk);
    chk("p1_valid", a_id_valid, 1);
    chk("p1_pc", a_id_pc, 32'h100);
    chk("p1_inst", a_id_inst, 32'h13);
    chk("p1_count", a_count, 1);
    cyc(); a_id_ready = 0;
    @(negedge clk);
    chk("p1_drained", a_count, 0);
    // fill, hold third offer, drain in order
    cyc(); push_a(32'h100, 32'hA0);
    cyc(); push_a(32'h104, 32'hA4);
    cyc(); push_a(32'h108, 32'hA8);
    @(negedge clk);
    chk("full_count", a_count, 2);
    chk("full_if_ready", a_if_ready, 0);
    chk("full_head", a_id_pc, 32'h100);
    cyc();
    @(negedge clk);
    chk("stall_count", a_count, 2);
    chk("stall_head", a_id_pc, 32'h100);
    chk("stall_inst", a_id_inst, 32'hA0);
    cyc(); a_id_ready = 1;
    @(negedge clk);
    chk("full_pop_head", a_id_pc, 32'h100);
    chk("full_pop_if_ready", a_if_ready, 0);
    cyc();
    @(negedge clk);
    chk("one_pop_count", a_count, 1);
    chk("one_pop_if_ready", a_if_ready, 1);
    chk("order_2", a_id_pc, 32'h104);
    cyc(); a_if_valid = 0;
    @(negedge clk);
    chk("order_3", a_id_pc, 32'h108);
    chk("order_3_inst", a_id_inst, 32'hA8);
    chk("order_3_count", a_count, 1);
    cyc();
    @(negedge clk);
    chk("empty_valid", a_id_valid, 0);
    chk("empty_pc", a_id_pc, 0);
    chk("empty_inst", a_id_inst, 0);
    // flush priority
    cyc(); a_id_ready = 0; push_a(32'h200, 32'hB0);
    cyc(); push_a(32'h204, 32'hB4);
    cyc(); push_a(32'h208, 32'hB8); a_flush = 1; a_id_ready = 1;
    @(negedge clk);
    chk("flush_id_valid", a_id_valid, 0);
    chk("flush_if_ready", a_if_ready, 0);
    chk("flush_pc", a_id_pc, 0);
    cyc(); a_flush = 0; a_if_valid = 0; a_id_ready = 0;
    @(negedge clk);
    chk("post_flush_count", a_count, 0);
    chk("post_flush_if_ready", a_if_ready, 1);
    // misalign from stored pc
    cyc(); push_a(32'h102, 32'hC0);
    cyc(); push_a(32'h104, 32'hC4);
    @(negedge clk);
    chk("mis_pc", a_id_pc, 32'h102);
    chk("mis_1", a_id_misalign, 1);
    cyc(); a_if_valid = 0; a_id_ready = 1;
    @(negedge clk);
    chk("mis_hold", a_id_misalign, 1);
    cyc();
    @(negedge clk);
    chk("mis_pc2", a_id_pc, 32'h104);
    chk("mis_0", a_id_misalign, 0);
    cyc(); a_id_ready = 0;
    // reset mid-operation
    cyc(); push_a(32'h300, 32'hD0);
    cyc(); rst = 1;
    @(negedge clk);
    chk("mid_rst_if_ready", a_if_ready, 0);
    chk("mid_rst_id_valid", a_id_valid, 0);
    cyc(); rst = 0; a_if_valid = 0;
    @(negedge clk);
    chk("mid_rst_count", a_count, 0);
    chk("mid_rst_if_ready1", a_if_ready, 1);
    // randomized traffic against a queue model
    for (int i = 0; i < 1000; i++) begin
      cyc();
      b_if_valid = $urandom_range(0, 1);
      b_id_ready = ($urandom_range(0, 3) != 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
      b_flush    = ($urandom_range(0, 31) == 0);
      b_if_pc    = $urandom;
      b_if_inst  = $urandom;
      @(negedge clk);
      n      = q.size();
      exp_ir = (n != 4) && !b_flush;
      exp_iv = (n != 0) && !b_flush;
      head   = exp_iv ? q[0] : 64'h0;
      chk("r_if_ready", b_if_ready, exp_ir);
      chk("r_id_valid", b_id_valid, exp_iv);
      chk("r_count", b_count, n);
      chk("r_pc", b_id_pc, head[63:32]);
      chk("r_inst", b_id_inst, head[31:0]);
      chk("r_mis", b_id_misalign, exp_iv && |head[33:32]);
      if (b_flush) q.delete();
      else begin
        if (exp_iv && b_id_ready) void'(q.pop_front());
        if (b_if_valid && exp_ir) q.push_back({b_if_pc, b_if_inst});
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
